array_mult_sequencer: RTL and testbench
=======================================

# array_mult_sequencer

Sequential 16x16 unsigned multiplier controller that time-multiplexes a single 15-bit carry-save adder row (`MultiAdd15`) over the 15 partial-product rows of an array multiplier, then resolves the final carry vector. It sits in the APU multiply path between the operand registers and the result bus, trading the area of a full array for a fixed 16-cycle latency.

## Interface
- No parameters; operand width is fixed at 16 bits by the 15-bit row.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; sampled only while `busy`=0.
- `multiplicand` input 16: operand A, unsigned; captured on accept.
- `multiplier` input 16: operand B, unsigned; captured on accept.
- `busy` output 1: high from the accept edge until the result is written.
- `done` output 1: one-cycle pulse; `product` is valid this cycle.
- `product` output 32: A*B; held until overwritten by the next completed operation.

## Operation
- States: IDLE, ACCUM, RESOLVE. Reset -> IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0.
- Accept: `start`=1 and `busy`=0 at an edge. Capture A and B. Set `row`=1, `sumReg`=A[14:0]&{15{B[0]}}, `carryReg`=0, `topReg`=A[15]&B[0], `lowReg[0]`=A[0]&B[0]. Go to ACCUM.
- ACCUM, row i (1..15), drives the row with x=A[14:0]&{15{B[i]}}, y={topReg, sumReg[14:1]}, cin=carryReg. On the edge: `lowReg[i]`=sum[0], `sumReg`=sum, `carryReg`=carryOut, `topReg`=A[15]&B[i]. After row 15, go to RESOLVE.
- RESOLVE: `product[31:16]` = {topReg, sumReg[14:1]} + carryReg, computed as a 15-bit add with carry-out giving bit 31. `product[15:0]`=`lowReg`. Pulse `done` and go to IDLE.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- A new accept is legal in the `done` cycle (`busy`=0 there). `product` keeps its old value until the new operation's RESOLVE.
- Reset mid-operation: immediate return to IDLE. The partial result is discarded and `product` is cleared to 0.

## Timing
- Accept at edge E0. `busy` is 1 after E0, through ACCUM edges E1..E15 and the RESOLVE edge E16. After E16, `busy`=0, `done`=1 for one cycle, and `product` is valid.
- Fixed latency: 16 cycles from the accept edge to `done`. Throughput is one result per 16 cycles with back-to-back `start`.
- Only one row evaluation happens per cycle. The combinational path is one `MultiAdd15` row plus AND gating; RESOLVE is one 15-bit ripple add.
- `done` and `busy` are registered outputs, with no combinational path from inputs.

## Structure
- Shared package `apu_pkg`:
  - state encoding constants ST_IDLE, ST_ACCUM, ST_RESOLVE;
  - MULT_ROWS=15;
  - OPERAND_W=16.
- One sub-module: a single instance of the existing `MultiAdd15` carry-save row, driven by the sequencer. The RESOLVE adder is inline in the sequencer.
- `row` counter: 4 bits.

## Test plan
- Basic multiply: A=3, B=5, `start` for 1 cycle -> `done` 16 cycles after the accept edge, `product`=0x0000000F, `busy` high for exactly 16 cycles.
- Worst-case carries: A=0xFFFF, B=0xFFFF -> `product`=0xFFFE0001. A=0x8000, B=0x8000 -> 0x40000000. A=0, B=0xFFFF -> 0.
- Back-to-back: A=0x1234, B=0x5678 accepted; a new `start` (A=7, B=9) in the `done` cycle -> first `product`=0x06260060, second `product`=0x0000003F, 16 cycles later.
- Ignored start: `start` with A=1, B=1 asserted mid-ACCUM of 0x00FF*0x0101 -> `product`=0x0000FFFF, and no extra `done` pulse.
- Reset mid-operation: assert `reset` at row 8 of 0xABCD*0x1234 -> `busy`, `done`, `product` all 0 immediately. A following 2*2 -> 4 after 16 cycles.
- Random: 10k random operand pairs against a reference A*B, with random `start` gaps and occasional `start` held high continuously.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU multiply-path definitions: operand geometry and sequencer state encoding.
package apu_pkg;

    localparam int OPERAND_W = 16;
    localparam int MULT_ROWS = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

endpackage

// File: rtl/array_mult_sequencer_multiadd15.sv
// One 15-bit carry-save adder row: three vectors in, sum and unshifted carry vector out.
module MultiAdd15 (
    input  logic [14:0] x_i,
    input  logic [14:0] y_i,
    input  logic [14:0] cin_i,
    output logic [14:0] sum_o,
    output logic [14:0] carry_o
);

    assign sum_o   = x_i ^ y_i ^ cin_i;
    assign carry_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);

endmodule

// File: rtl/array_mult_sequencer.sv
// Sequential 16x16 unsigned multiplier: reuses one MultiAdd15 row over 15 partial-product
// rows, then resolves the remaining sum/carry pair with a single ripple add.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; product holds last result
// ST_ACCUM   | folding partial-product row row_q (1..15) into sum/carry
// ST_RESOLVE | final 15-bit add of sum/carry, write product, pulse done
module array_mult_sequencer
    import apu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [OPERAND_W-1:0]   multiplicand,
    input  logic [OPERAND_W-1:0]   multiplier,
    output logic                   busy,
    output logic                   done,
    output logic [2*OPERAND_W-1:0] product
);

    state_e         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    b_q, b_d;
    logic [14:0]    sum_q, sum_d;
    logic [14:0]    carry_q, carry_d;
    logic           top_q, top_d;
    logic [15:0]    low_q, low_d;
    logic [31:0]    product_q, product_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [14:0]    row_x, row_y, ma_sum, ma_carry;
    logic [15:0]    resolve_sum;

    // Previous row's sum is shifted right one place; its LSB has already retired to low_q.
    assign row_x = a_q[14:0] & {15{b_q[row_q]}};
    assign row_y = {top_q, sum_q[14:1]};

    MultiAdd15 u_row (
        .x_i     (row_x),
        .y_i     (row_y),
        .cin_i   (carry_q),
        .sum_o   (ma_sum),
        .carry_o (ma_carry)
    );

    assign resolve_sum = {1'b0, row_y} + {1'b0, carry_q};

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        top_d     = top_q;
        low_d     = low_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = multiplicand;
                    b_d     = multiplier;
                    row_d   = 4'd1;
                    sum_d   = multiplicand[14:0] & {15{multiplier[0]}};
                    carry_d = '0;
                    top_d   = multiplicand[15] & multiplier[0];
                    low_d   = {15'd0, multiplicand[0] & multiplier[0]};
                    busy_d  = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                low_d[row_q] = ma_sum[0];
                sum_d        = ma_sum;
                carry_d      = ma_carry;
                top_d        = a_q[15] & b_q[row_q];
                row_d        = row_q + 4'd1;
                if (row_q == 4'(MULT_ROWS)) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                product_d = {resolve_sum, low_q};
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            top_q     <= 1'b0;
            low_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            top_q     <= top_d;
            low_q     <= low_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_array_mult_sequencer.sv
// Self-checking bench for array_mult_sequencer: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a cycle-level arithmetic reference.
module tb_array_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    array_mult_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 16'hDEAD;
        multiplier   = 16'hBEEF;
    endtask

    task automatic wait_done(output logic [31:0] p, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t        vecs[10];
    logic [31:0] p;
    int          lat, bcnt, extra_done;

    logic [15:0] ma, mb, ra, rb;
    logic [31:0] m_prod;
    int          m_cnt, rand_fail_prints;
    logic        m_done, hold, st;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[4] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[6] = '{16'h0100, 16'h0100, 32'h00010000};
        vecs[7] = '{16'hFFFF, 16'h8000, 32'h7FFF8000};
        vecs[8] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[9] = '{16'h0002, 16'h0002, 32'h00000004};

        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].a, vecs[i].b);
            wait_done(p, lat, bcnt);
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd16);
            chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            chk($sformatf("vec%0d_product_held", i), product, vecs[i].exp);
        end

        // Back-to-back: next accept lands in the done cycle.
        accept(16'h1234, 16'h5678);
        wait_done(p, lat, bcnt);
        chk("b2b_first_product", p, 32'h06260060);
        accept(16'h0007, 16'h0009);
        chk("b2b_product_kept_during_op", product, 32'h06260060);
        wait_done(p, lat, bcnt);
        chk("b2b_second_product", p, 32'h0000003F);
        chk("b2b_second_latency", 32'(lat), 32'd16);
        @(negedge clk);

        // Start pulsed mid-ACCUM must be ignored.
        accept(16'h00FF, 16'h0101);
        repeat (5) @(negedge clk);
        start = 1'b1; multiplicand = 16'h0001; multiplier = 16'h0001;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(p, lat, bcnt);
        chk("ignored_start_product", p, 32'h0000FFFF);
        chk("ignored_start_latency", 32'(lat + 8), 32'd16);
        extra_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        chk("ignored_start_no_extra_op", 32'(extra_done), 32'd0);

        // Reset while row 8 is being accumulated.
        accept(16'hABCD, 16'h1234);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_product", product, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        accept(16'h0002, 16'h0002);
        wait_done(p, lat, bcnt);
        chk("post_reset_product", p, 32'h00000004);
        chk("post_reset_latency", 32'(lat), 32'd16);

        // Random traffic against a transaction-level model.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0; m_done = 1'b0; m_prod = '0; ma = '0; mb = '0;
        hold = 1'b0; rand_fail_prints = 0;
        for (int c = 0; c < 30000; c++) begin
            checks++;
            if (busy !== (m_cnt != 0) || done !== m_done || product !== m_prod) begin
                failures++;
                if (rand_fail_prints < 20) begin
                    rand_fail_prints++;
                    $display("FAIL random_cycle%0d: got busy=%0b done=%0b product=0x%08h expected busy=%0b done=%0b product=0x%08h",
                             c, busy, done, product, (m_cnt != 0), m_done, m_prod);
                end
            end
            if ($urandom_range(0, 199) == 0) hold = ~hold;
            st = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
            ra = pick_operand();
            rb = pick_operand();
            start = st; multiplicand = ra; multiplier = rb;
            m_done = 1'b0;
            if (m_cnt != 0) begin
                if (m_cnt == 1) begin
                    m_done = 1'b1;
                    m_prod = {16'd0, ma} * {16'd0, mb};
                end
                m_cnt--;
            end else if (st) begin
                ma    = ra;
                mb    = rb;
                m_cnt = 16;
            end
            @(negedge clk);
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
